seq_detect_scheduler: RTL and testbench
=======================================

// Module: seq_detect_scheduler
// PURPOSE
//  Round-robin scheduler that shares one bit-serial, overlapping 3-bit pattern detector between NREQ requesters.
//  Each request carries a W-bit word. The block grants one requester, shifts its word MSB-first through the detector,
//  counts the matches against two programmable patterns, and returns the count to that requester.
//  Sits between the packet-parsing front end and the serial sequence-detect datapath.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  W     8  word width, bits shifted per job (>=3)
//  CW    4  hit-count width; must satisfy 2**CW > W-2
// PORTS
//  clk       in   1        clock
//  rst       in   1        synchronous, active-high reset
//  req       in   NREQ     per-requester request, level; hold until granted
//  data      in   NREQ*W   requester k word at [k*W +: W]
//  pat_a     in   3        pattern A, window order {oldest..newest}; sampled at grant
//  pat_b     in   3        pattern B; sampled at grant
//  grant     out  NREQ     one-hot, one-cycle pulse; data/patterns captured on this edge
//  busy      out  1        high in SHIFT and DONE
//  done      out  1        one-cycle pulse; result valid
//  done_id   out  clog2(NREQ)  index of the requester owning the result
//  hit_cnt   out  CW       number of matching 3-bit windows in the word
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, busy=0, done=0, done_id=0, hit_cnt=0, rr pointer=NREQ-1 (requester 0 wins first).
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE (cycle 0), req!=0:
//   - Round-robin pick, searching from ptr+1 upward with wrap.
//   - At the edge: ptr<=k, word<=data[k], pats latched, bitcnt<=0, window<=0, cnt<=0, state<=SHIFT.
//   - grant[k]=1 during cycle 1 only.
//  req==0 in IDLE: stay; all outputs low except done_id and hit_cnt, which hold their last values.
//  SHIFT (cycles 1..W): each edge consumes bit b = word[W-1-bitcnt].
//   - nw = {window[1:0], b}.
//   - If bitcnt>=2 and (nw==pat_a || nw==pat_b): cnt<=cnt+1.
//   - A window matching both patterns counts once. Windows overlap; max count is W-2.
//   - Shift uses word bits, not req; req may drop any time after grant.
//   - After the edge consuming bitcnt==W-1: state<=DONE, hit_cnt<=final cnt, done_id<=ptr.
//  DONE (cycle W+1): done=1, busy=1. No arbitration this cycle. Next state IDLE (cycle W+2 arbitrates).
//  Job latency: req sampled in cycle 0 -> done in cycle W+1. Throughput: one job per W+2 cycles.
//  Requests are ignored while busy. No queueing beyond the level req itself.
//  A requester still asserting req in IDLE after its own done is re-granted only if it wins round-robin.
//  Detector history (window) clears at every grant; jobs never share windows.
//  Changes to pat_a/pat_b mid-job take effect at the next grant only.
//  rst in any state, including mid-SHIFT: next cycle is IDLE with reset values. The aborted job never produces done.
//  hit_cnt arithmetic is unsigned. With CW sized per PARAMETERS, no saturation is needed.
// STRUCTURE
//  Package seq_sched_pkg:
//   - state enum {IDLE, SHIFT, DONE}.
//   - PATW=3 constant.
//   - function match3(win, pa, pb).
//  Sub-module seq_rr_arbiter (NREQ): inputs req, ptr, en; outputs one-hot gnt and index. Pure round-robin search.
//  The top holds the FSM, word/window/bit counters and result registers.
// TESTING
//  1 NREQ=4, W=8, req=4'b0001, data0=8'b1001_0010, pat_a=3'b100, pat_b=3'b010
//    -> grant=0001 in cycle 1, done in cycle 9, done_id=0, hit_cnt=4.
//  2 data=8'h00, pat_a=pat_b=3'b000 -> hit_cnt=6 (double match counted once);
//    data=8'hFF, patterns 100/010 -> hit_cnt=0.
//  3 req=4'b1111 held from reset -> grants 0001, 0010, 0100, 1000, 0001 at 10-cycle spacing; done_id 0,1,2,3,0.
//  4 Job 1 granted; req[2] rises in cycle 3; pat_a changed in cycle 4
//    -> req[2] granted in cycle 11; job 1 uses the old pattern, job 2 the new one.
//  5 rst asserted in cycle 5 of a job -> cycle 6: busy=0, grant=0, done=0, hit_cnt=0; no done for the aborted job.
//    A new req afterwards is served with requester 0 priority.
//  6 Requester drops req in its grant cycle -> job completes normally with correct hit_cnt.
//    A req pulse that lasts only during busy is never granted.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler in front of the
// bit-serial 3-bit pattern detector.
package seq_sched_pkg;

  localparam int PATW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // A window that equals both patterns still counts as a single hit.
  function automatic logic match3(input logic [PATW-1:0] win,
                                  input logic [PATW-1:0] pa,
                                  input logic [PATW-1:0] pb);
    return (win == pa) || (win == pb);
  endfunction

endpackage

// File: rtl/seq_rr_arbiter.sv
// Combinational round-robin search: the first active request after ptr_i
// (with wrap) wins. Outputs are zero when en_i is low.
module seq_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] cand_s;
  logic          found_s;

  // The candidate order starts one past the previous winner, so the last
  // winner has the lowest priority.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = IW'((int'(ptr_i) + i) % NREQ);
      if (en_i && !found_s && req_i[cand_s]) begin
        found_s        = 1'b1;
        gnt_o[cand_s]  = 1'b1;
        idx_o          = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one MSB-first, overlapping 3-bit pattern
// detector between NREQ requesters; returns a hit count per job.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int CW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        data,
  input  logic [PATW-1:0]          pat_a,
  input  logic [PATW-1:0]          pat_b,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [CW-1:0]            hit_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(W);

  state_e            state_q,   state_d;
  logic [IW-1:0]     ptr_q,     ptr_d;
  logic [W-1:0]      word_q,    word_d;
  logic [PATW-1:0]   pa_q,      pa_d;
  logic [PATW-1:0]   pb_q,      pb_d;
  logic [BW-1:0]     bitcnt_q,  bitcnt_d;
  logic [PATW-2:0]   win_q,     win_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [NREQ-1:0]   grant_q,   grant_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic [IW-1:0]     done_id_q, done_id_d;
  logic [CW-1:0]     hit_cnt_q, hit_cnt_d;

  logic              arb_en_s;
  logic [NREQ-1:0]   arb_gnt_s;
  logic [IW-1:0]     arb_idx_s;
  logic [W-1:0]      sel_word_s;
  logic              bit_s;
  logic [PATW-1:0]   nw_s;
  logic              hit_s;
  logic              last_s;
  logic [CW-1:0]     cnt_inc_s;

  assign arb_en_s = (state_q == S_IDLE);

  seq_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (arb_en_s),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s)
  );

  // The word register shifts left, so its MSB is always the next bit to consume.
  assign bit_s     = word_q[W-1];
  assign nw_s      = {win_q, bit_s};
  assign hit_s     = (bitcnt_q >= BW'(2)) && match3(nw_s, pa_q, pb_q);
  assign last_s    = (bitcnt_q == BW'(W-1));
  assign cnt_inc_s = cnt_q + CW'(hit_s);

  always_comb begin
    sel_word_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel_word_s = sel_word_s | (data[k*W +: W] & {W{arb_gnt_s[k]}});
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    word_d    = word_q;
    pa_d      = pa_q;
    pb_d      = pb_q;
    bitcnt_d  = bitcnt_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d  = S_SHIFT;
          ptr_d    = arb_idx_s;
          word_d   = sel_word_s;
          pa_d     = pat_a;
          pb_d     = pat_b;
          bitcnt_d = '0;
          win_d    = '0;
          cnt_d    = '0;
          grant_d  = arb_gnt_s;
          busy_d   = 1'b1;
        end else begin
          busy_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        word_d   = {word_q[W-2:0], 1'b0};
        win_d    = nw_s[PATW-2:0];
        cnt_d    = cnt_inc_s;
        bitcnt_d = bitcnt_q + BW'(1);
        if (last_s) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          hit_cnt_d = cnt_inc_s;
          done_id_d = ptr_q;
        end else begin
          state_d   = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IW'(NREQ-1);
      word_q    <= '0;
      pa_q      <= '0;
      pb_q      <= '0;
      bitcnt_q  <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      word_q    <= word_d;
      pa_q      <= pa_d;
      pb_q      <= pb_d;
      bitcnt_q  <= bitcnt_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench: a cycle-level reference model predicts grants and results,
// and an independent monitor checks whatever the scheduler presents.
module tb_seq_detect_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] data = '0;
  logic [2:0]        pat_a = 3'd0;
  logic [2:0]        pat_b = 3'd0;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              done;
  logic [IW-1:0]     done_id;
  logic [CW-1:0]     hit_cnt;

  seq_detect_scheduler #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .pat_a   (pat_a),
    .pat_b   (pat_b),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
    int id;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  int   tests = 0;
  int   fails = 0;
  int   m_ptr = NREQ - 1;
  int   m_free = 0;
  int   b_lo = 0;
  int   b_hi = -1;
  bit   mon_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Count every 3-bit window of the word, scanning MSB-first.
  function automatic int ref_count(input logic [W-1:0] w, input logic [2:0] a, input logic [2:0] b);
    int n = 0;
    for (int i = 0; i <= W - 3; i++) begin
      logic [2:0] win;
      win = w[W-1-i -: 3];
      if (win == a || win == b) n++;
    end
    return n;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int j = 1; j <= NREQ; j++) begin
      if (r[(ptr + j) % NREQ]) return (ptr + j) % NREQ;
    end
    return -1;
  endfunction

  // Reference model: samples the inputs of cycle cyc on the edge that ends it.
  always @(posedge clk) begin
    if (rst) begin
      gq.delete();
      dq.delete();
      m_ptr  <= NREQ - 1;
      m_free <= 0;
      b_hi   <= -1;
    end else if (cyc >= m_free && req != '0) begin
      automatic int         k = rr_pick(m_ptr, req);
      automatic logic [W-1:0] w = data[k*W +: W];
      gq.push_back('{cyc + 1, 1 << k, k});
      dq.push_back('{cyc + W + 1, ref_count(w, pat_a, pat_b), k});
      m_ptr  <= k;
      m_free <= cyc + W + 2;
      b_lo   <= cyc + 1;
      b_hi   <= cyc + W + 1;
    end
  end

  // Monitor: pops an expectation whenever the DUT pulses grant or done.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("busy", int'(busy), int'(cyc >= b_lo && cyc <= b_hi));
      if (grant != '0) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", int'(grant), 0);
        end else begin
          automatic exp_t e = gq.pop_front();
          chk("grant_cycle", cyc, e.cyc);
          chk("grant", int'(grant), e.val);
        end
      end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
        chk("grant_missing", 0, gq[0].val);
        void'(gq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          automatic exp_t e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_id", int'(done_id), e.id);
          chk("hit_cnt", int'(hit_cnt), e.val);
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        chk("done_missing", 0, 1);
        void'(dq.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic one_job(input logic [NREQ-1:0] r);
    req = r;
    step(1);
    req = '0;
    step(W + 3);
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) data[k*W +: W] = W'($urandom);
    step(3);
    @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_hit_cnt", int'(hit_cnt), 0);
    mon_on = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);

    // Directed pattern cases
    data[0 +: W] = 8'b1001_0010; pat_a = 3'b100; pat_b = 3'b010;
    one_job(4'b0001);
    data[0 +: W] = 8'h00; pat_a = 3'b000; pat_b = 3'b000;
    one_job(4'b0001);
    data[0 +: W] = 8'hFF; pat_a = 3'b100; pat_b = 3'b010;
    one_job(4'b0001);

    // All requesters held from reset
    rst = 1'b1; req = 4'b1111;
    step(2);
    rst = 1'b0;
    step(45);
    req = '0;
    step(W + 3);

    // Late request and mid-job pattern change
    req = 4'b0010;
    step(1);
    req = '0;
    step(2);
    req = 4'b0100;
    step(1);
    pat_a = 3'b111;
    step(7);
    req = '0;
    step(W + 3);

    // Reset in the middle of a job, then requester 0 priority
    req = 4'b0100;
    step(1);
    req = '0;
    step(4);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_grant", int'(grant), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_hit_cnt", int'(hit_cnt), 0);
    step(1);
    rst = 1'b0;
    one_job(4'b1111);

    // Request pulse confined to a busy window is never granted
    req = 4'b1000;
    step(1);
    req = '0;
    step(2);
    req = 4'b0010;
    step(3);
    req = '0;
    step(W + 3);

    // Randomised traffic with occasional resets and pattern changes
    for (int i = 0; i < 500; i++) begin
      req   = NREQ'($urandom);
      data[$urandom_range(NREQ-1, 0) * W +: W] = W'($urandom);
      if ($urandom_range(3, 0) == 0) pat_a = 3'($urandom);
      if ($urandom_range(3, 0) == 0) pat_b = 3'($urandom);
      rst = ($urandom_range(99, 0) == 0);
      step(1);
    end
    rst = 1'b0;
    req = '0;
    step(W + 4);

    chk("grant_queue_drained", gq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
